// File: rtl/ysyx_24070016_ifu.sv
// Instruction fetch: one outstanding imem read, returned words queued with PC/fault toward decode.
// Request issued the cycle after IDLE; decode stalls stop issue once the buffer would overflow.
module ysyx_24070016_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_KILL_REQ,
        S_KILL_WAIT
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_req_addr;
    logic            r_req_vld;
    logic            r_halted;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [31:0]     r_buf_dat [DEPTH];
    logic [31:0]     r_buf_pc  [DEPTH];
    logic            r_buf_err [DEPTH];

    logic            w_halted;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;
    logic [31:0]     w_pc_inc;

    // A halt seen this cycle already blocks the next issue decision.
    assign w_halted    = r_halted | halt;
    assign w_push      = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_pop       = inst_valid && inst_ready;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_pc_inc    = r_fetch_pc + 32'd4;

    assign imem_req_valid = r_req_vld;
    assign imem_req_addr  = r_req_addr;
    assign inst_valid     = (r_count != '0);
    assign inst           = r_buf_dat[r_rd_ptr];
    assign inst_pc        = r_buf_pc[r_rd_ptr];
    assign inst_err       = r_buf_err[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_req_vld  <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_dat[i] <= '0;
                r_buf_pc[i]  <= '0;
                r_buf_err[i] <= 1'b0;
            end
        end else begin
            if (halt) begin
                r_halted <= 1'b1;
            end
            if (w_push) begin
                r_buf_dat[r_wr_ptr] <= imem_rsp_data;
                r_buf_pc[r_wr_ptr]  <= r_req_addr;
                r_buf_err[r_wr_ptr] <= imem_rsp_err;
            end
            if (redirect_valid) begin
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else begin
                r_count <= w_count_nxt;
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                    r_fetch_pc <= w_pc_inc;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (!redirect_valid && !w_halted && (r_count < FULL)) begin
                        r_state    <= S_REQ;
                        r_req_vld  <= 1'b1;
                        r_req_addr <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_req_vld <= 1'b0;
                        r_state   <= redirect_valid ? S_KILL_WAIT : S_WAIT;
                    end else if (redirect_valid) begin
                        r_state <= S_KILL_REQ;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_state <= imem_rsp_valid ? S_IDLE : S_KILL_WAIT;
                    end else if (imem_rsp_valid) begin
                        // Chain straight into the next fetch when the buffer has room.
                        if (!w_halted && (w_count_nxt < FULL)) begin
                            r_state    <= S_REQ;
                            r_req_vld  <= 1'b1;
                            r_req_addr <= w_pc_inc;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_KILL_REQ: begin
                    if (imem_req_ready) begin
                        r_req_vld <= 1'b0;
                        r_state   <= S_KILL_WAIT;
                    end
                end
                S_KILL_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_req_vld <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_24070016_ifu.sv
// Bench for ysyx_24070016_ifu: memory responder with programmable latency plus
// request/instruction scoreboards filled by each scenario task.
module tb_ysyx_24070016_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        imem_rsp_err   = 1'b0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
        logic        err;
    } ent_t;

    ent_t        inst_q[$];
    logic [31:0] req_q[$];
    int          acc_cyc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          rsp_lat = 1;
    int          rsp_cnt = 0;
    bit          rsp_pend = 1'b0;
    logic [31:0] rsp_addr = 32'h0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    ysyx_24070016_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic ent_t mk(input logic [31:0] pc, input logic e);
        return {pc, mem_word(pc), e};
    endfunction

    // Memory model: capture an accepted request mid-cycle, answer rsp_lat cycles later.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            rsp_pend = 1'b0;
        end else if (imem_req_valid && imem_req_ready) begin
            rsp_pend = 1'b1;
            rsp_cnt  = rsp_lat;
            rsp_addr = imem_req_addr;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        if (rsp_pend) begin
            rsp_cnt--;
            if (rsp_cnt <= 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(rsp_addr);
                imem_rsp_err   = (rsp_addr == err_addr);
                rsp_pend       = 1'b0;
            end
        end
    end

    // Scoreboard: every accepted request and every consumed instruction is checked.
    always @(negedge clk) begin
        logic [31:0] exp_a;
        ent_t        exp_e;
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                acc_cnt++;
                acc_cyc_q.push_back(cyc);
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_addr: unexpected request addr=%h, required none", imem_req_addr);
                end else begin
                    exp_a = req_q.pop_front();
                    if (imem_req_addr !== exp_a) begin
                        errors++;
                        $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_a);
                    end
                end
            end
            if (inst_valid && inst_ready) begin
                checks++;
                if (inst_q.size() == 0) begin
                    errors++;
                    $display("FAIL inst_out: unexpected inst pc=%h, required none", inst_pc);
                end else begin
                    exp_e = inst_q.pop_front();
                    if (inst_pc !== exp_e.pc || inst !== exp_e.dat || inst_err !== exp_e.err) begin
                        errors++;
                        $display("FAIL inst_out: got pc=%h inst=%h err=%b, required pc=%h inst=%h err=%b",
                                 inst_pc, inst, inst_err, exp_e.pc, exp_e.dat, exp_e.err);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        rsp_lat        = 1;
        err_addr       = 32'hFFFF_FFFF;
        repeat (2) tick();
        req_q.delete();
        inst_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int n, output bit ok);
        int i = 0;
        while (acc_cnt < n && i < 60) begin
            tick();
            i++;
        end
        ok = (acc_cnt >= n);
    endtask

    task automatic wait_drain(output bit ok);
        int i = 0;
        while ((req_q.size() != 0 || inst_q.size() != 0) && i < 60) begin
            tick();
            i++;
        end
        ok = (req_q.size() == 0 && inst_q.size() == 0);
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, inst_valid, inst_err} !== 3'b000 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req_v=%b inst_v=%b err=%b inst=%h pc=%h, required all 0",
                     imem_req_valid, inst_valid, inst_err, inst, inst_pc);
        end
        checks++;
        if (imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_addr: got %h, required %h", imem_req_addr, RST_PC);
        end
        do_reset();
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: got valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        bit ok;
        int base;
        int sz;
        do_reset();
        base = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            req_q.push_back(RST_PC + 32'(4 * i));
            inst_q.push_back(mk(RST_PC + 32'(4 * i), 1'b0));
        end
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_acc(base + 3, ok);
        imem_req_ready = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_accepts: got %0d, required 3", acc_cnt - base);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_drain: got %0d req %0d inst left, required 0 0", req_q.size(), inst_q.size());
        end
        sz = acc_cyc_q.size();
        checks++;
        if (sz < 3 || acc_cyc_q[sz-1] - acc_cyc_q[sz-2] != 2 || acc_cyc_q[sz-2] - acc_cyc_q[sz-3] != 2) begin
            errors++;
            $display("FAIL stream_rate: got gaps %0d %0d, required 2 2",
                     acc_cyc_q[sz-2] - acc_cyc_q[sz-3], acc_cyc_q[sz-1] - acc_cyc_q[sz-2]);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int base;
        do_reset();
        base = acc_cnt;
        req_q.push_back(RST_PC);
        req_q.push_back(RST_PC + 32'd4);
        imem_req_ready = 1'b1;
        repeat (12) tick();
        checks++;
        if (acc_cnt - base != 2 || imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: got accepts=%0d req_v=%b inst_v=%b, required 2 0 1",
                     acc_cnt - base, imem_req_valid, inst_valid);
        end
        req_q.push_back(RST_PC + 32'd8);
        for (int i = 0; i < 3; i++) inst_q.push_back(mk(RST_PC + 32'(4 * i), 1'b0));
        inst_ready = 1'b1;
        tick();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_restart_early: got req_v=%b, required 0", imem_req_valid);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 32'd8) begin
            errors++;
            $display("FAIL bp_restart: got valid=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, RST_PC + 32'd8);
        end
        tick();
        imem_req_ready = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_drain: got %0d req %0d inst left, required 0 0", req_q.size(), inst_q.size());
        end
    endtask

    task automatic test_redirect();
        bit ok;
        int base;
        do_reset();
        base    = acc_cnt;
        rsp_lat = 3;
        req_q.push_back(RST_PC);
        req_q.push_back(RST_PC + 32'd4);
        imem_req_ready = 1'b1;
        wait_acc(base + 2, ok);
        checks++;
        if (!ok || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_setup: got accepts=%0d inst_v=%b, required 2 1", acc_cnt - base, inst_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1002;
        req_q.push_back(32'h8000_1000);
        inst_q.push_back(mk(32'h8000_1000, 1'b0));
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: got inst_v=%b, required 0", inst_valid);
        end
        inst_ready = 1'b1;
        wait_acc(base + 3, ok);
        imem_req_ready = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL redir_refetch: got accepts=%0d, required 3", acc_cnt - base);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL redir_drain: got %0d req %0d inst left, required 0 0", req_q.size(), inst_q.size());
        end
    endtask

    task automatic test_kill_req();
        bit ok;
        int base;
        do_reset();
        base = acc_cnt;
        req_q.push_back(RST_PC);
        req_q.push_back(32'h8000_2000);
        inst_q.push_back(mk(32'h8000_2000, 1'b0));
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
                errors++;
                $display("FAIL kill_hold[%0d]: got valid=%b addr=%h, required 1 %h", i, imem_req_valid, imem_req_addr, RST_PC);
            end
            redirect_valid = (i == 1);
            redirect_pc    = 32'h8000_2000;
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_acc(base + 2, ok);
        imem_req_ready = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL kill_accepts: got %0d, required 2", acc_cnt - base);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL kill_drain: got %0d req %0d inst left, required 0 0", req_q.size(), inst_q.size());
        end
    endtask

    task automatic test_fault();
        bit ok;
        int base;
        do_reset();
        base     = acc_cnt;
        err_addr = RST_PC + 32'd4;
        for (int i = 0; i < 3; i++) begin
            req_q.push_back(RST_PC + 32'(4 * i));
            inst_q.push_back(mk(RST_PC + 32'(4 * i), i == 1));
        end
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_acc(base + 3, ok);
        imem_req_ready = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fault_drain: got %0d req %0d inst left, required 0 0", req_q.size(), inst_q.size());
        end
    endtask

    task automatic test_halt();
        bit ok;
        int base;
        do_reset();
        base    = acc_cnt;
        rsp_lat = 2;
        req_q.push_back(RST_PC);
        inst_q.push_back(mk(RST_PC, 1'b0));
        imem_req_ready = 1'b1;
        wait_acc(base + 1, ok);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        repeat (8) tick();
        checks++;
        if (!ok || inst_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_stop: got inst_v=%b req_v=%b, required 1 0", inst_valid, imem_req_valid);
        end
        inst_ready = 1'b1;
        wait_drain(ok);
        tick();
        checks++;
        if (!ok || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_drain: got inst_v=%b left=%0d, required 0 0", inst_valid, inst_q.size());
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (imem_req_valid !== 1'b0 || acc_cnt - base != 1) begin
            errors++;
            $display("FAIL halt_redirect: got req_v=%b accepts=%0d, required 0 1", imem_req_valid, acc_cnt - base);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int base;
        do_reset();
        base    = acc_cnt;
        rsp_lat = 3;
        req_q.push_back(RST_PC);
        req_q.push_back(RST_PC + 32'd4);
        imem_req_ready = 1'b1;
        wait_acc(base + 2, ok);
        checks++;
        if (!ok || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: got accepts=%0d inst_v=%b, required 2 1", acc_cnt - base, inst_valid);
        end
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req_valid, inst_valid, inst_err} !== 3'b000 || inst !== 32'h0 || inst_pc !== 32'h0
            || imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL arst_outputs: got req_v=%b inst_v=%b err=%b inst=%h pc=%h addr=%h, required 0 0 0 0 0 %h",
                     imem_req_valid, inst_valid, inst_err, inst, inst_pc, imem_req_addr, RST_PC);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL arst_stale_rsp: got inst_v=%b req_v=%b addr=%h, required 0 1 %h",
                     inst_valid, imem_req_valid, imem_req_addr, RST_PC);
        end
        rsp_lat = 1;
        req_q.push_back(RST_PC);
        inst_q.push_back(mk(RST_PC, 1'b0));
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_acc(base + 3, ok);
        imem_req_ready = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL arst_refetch: got %0d req %0d inst left, required 0 0", req_q.size(), inst_q.size());
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_kill_req();
        test_fault();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ysyx_24070016_ifu.md
Name: ysyx_24070016_ifu

Overview:
- Instruction fetch unit: the producer side of the instruction word consumed by the decode stage.
- Owns the fetch PC and issues 32-bit instruction reads to instruction memory over a valid/ready request and valid response interface, one outstanding request at most.
- Buffers returned words, each with its PC and error flag, in a small FIFO and presents them to decode under a valid/ready handshake.
- Supports redirect (flush and new PC) and halt (stop fetching after ebreak).

Parameters:
- RESET_PC, 32'h8000_0000, fetch PC loaded at reset.
- DEPTH, 2, instruction buffer entries (power of two, 2..8).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  read data valid, single-cycle pulse
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  buffer head valid to decode
- inst_ready  in  1  decode consumes head
- inst  out  32  head instruction word
- inst_pc  out  32  head PC
- inst_err  out  1  head fetch fault
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, treated as 0
- halt  in  1  stop issuing fetches; sticky until reset

Behaviour:
- Reset values: fetch_pc=RESET_PC, state IDLE, FIFO count 0, halted 0. All outputs 0; imem_req_addr shows fetch_pc.
- States:
  - IDLE: no request.
  - REQ: request pending.
  - WAIT: awaiting response.
  - KILL_REQ: pending request whose data must be dropped.
  - KILL_WAIT: awaiting a response to drop.
- imem_req_valid = (state==REQ or KILL_REQ). imem_req_addr = address latched on entry to REQ. Both are held stable until imem_req_ready is sampled high; a request is never withdrawn.
- IDLE->REQ when !halted and count<DEPTH. Since only one request is outstanding, space for its response is guaranteed.
- REQ->WAIT on imem_req_ready. KILL_REQ->KILL_WAIT on imem_req_ready.
- WAIT on imem_rsp_valid:
  - Push {rsp_data, req addr, rsp_err}; fetch_pc += 4 (mod 2^32, wraps from FFFF_FFFC to 0).
  - Next state is REQ if !halted and post-push/pop count<DEPTH, else IDLE.
  - Peak rate: one instruction per 2 cycles.
- KILL_WAIT on imem_rsp_valid: discard the response, go to IDLE.
- imem_rsp_valid in IDLE/REQ/KILL_REQ is ignored.
- Fault responses: push with inst_err=1 and advance the PC normally. Decode decides what to do with them.
- Redirect has priority over push/pop in the same cycle:
  - FIFO count <= 0.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - State mapping: REQ accepted this cycle -> KILL_WAIT; REQ not accepted -> KILL_REQ; WAIT -> KILL_WAIT, or IDLE if imem_rsp_valid in the same cycle (response dropped); KILL_* unchanged (KILL_WAIT with rsp -> IDLE); IDLE stays IDLE.
  - After a kill completes, the next request uses the redirect PC.
- Halt: halted <= 1 on halt=1 and stays set until reset.
  - No new request is started once halted.
  - An in-flight request completes and is pushed normally.
  - FIFO contents are still drained by inst_ready.
  - Redirect while halted still updates the PC and flushes, but issues no fetch.
- Output side: inst_valid = (count!=0). inst/inst_pc/inst_err = head entry. Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Outputs come from registers; no combinational path from inst_ready to imem_req_*.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and never overflows, by the issue rule.
- Async reset mid-transaction: everything returns to reset values immediately. A response that arrives later is ignored because state is IDLE.

Test Plan:
- Reset, imem_req_ready=1, rsp 1 cycle later, inst_ready=1 -> addresses 8000_0000, 8000_0004, 8000_0008; inst_pc matches; one request every 2 cycles.
- inst_ready=0, DEPTH=2 -> exactly 2 requests (8000_0000, 8000_0004), then req_valid stays 0. Raising inst_ready restarts fetch at 8000_0008 the cycle after count drops.
- Redirect to 8000_1002 during WAIT with 1 buffered entry -> inst_valid=0 next cycle. The in-flight response (pc 8000_0004) is dropped. Next request addr=8000_1000.
- imem_req_ready=0 for 5 cycles, redirect in cycle 2 -> addr stays 8000_0000 until accepted; the response is discarded; the next request goes to the redirect PC.
- imem_rsp_err=1 on the second fetch -> entry pc 8000_0004 carries inst_err=1; fetch continues at 8000_0008.
- halt pulsed while WAIT -> that response is delivered, no further requests ever, and inst_valid drops after the buffer drains. Asserting rst_n=0 mid-WAIT -> all outputs 0 immediately.
